dot_product_acc: RTL and testbench

- Sequential stage directly downstream of the 4x4 array multiplier.
- Consumes the 8-bit product stream and accumulates LEN products, or fewer if ended early by in_last, into one dot-product result.
- Delivers the result with a valid/ready handshake to the next stage.
- Single clock domain; the upstream multiplier is combinational, so in_prod is sampled only on accepted beats.

---
 rtl/dot_product_acc.sv | 102 ++++++++++
 tb/tb_dot_product_acc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_acc.sv
// dot_product_acc: accumulates up to LEN unsigned 8-bit products into one result handed off via valid/ready.
// Optional DOTACC_SAT_EN: saturate the accumulator on carry-out instead of wrapping.
module dot_product_acc #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned LEN   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W:0]   cnt_inc;
    logic             beat;

    assign in_ready = (state == ACCUM) && !clr && rst_n;
    assign beat     = in_valid && in_ready;
    assign sum_ext  = {1'b0, acc} + (ACC_W+1)'(in_prod);
    assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);

    // Result ports expose the live accumulator; only meaningful in HOLD.
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        if (clr) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        cnt_nxt = cnt_inc[CNT_W-1:0];
                        if (sum_ext[ACC_W]) begin
                            ovf_nxt = 1'b1;
                        end
`ifdef DOTACC_SAT_EN
                        acc_nxt = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
                        acc_nxt = sum_ext[ACC_W-1:0];
`endif
                        if (in_last || (cnt_inc == (CNT_W+1)'(LEN))) begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Handshake frees the accumulator; new beats start the cycle after.
                    if (out_ready) begin
                        state_nxt = ACCUM;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_acc.sv
// Self-checking bench for dot_product_acc: three parameterisations checked against a sum-of-terms model.
module tb_dot_product_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] clr;
    logic [2:0] in_valid;
    logic [2:0] in_last;
    logic [2:0] out_ready;
    logic [7:0] in_prod [3];
    wire  [2:0] in_ready;
    wire  [2:0] out_valid;
    wire  [2:0] out_ovf;
    wire  [7:0] out_count [3];
    wire  [15:0] sum0;
    wire  [15:0] sum1;
    wire  [9:0]  sum2;

    int checks = 0;
    int errors = 0;

    longint m_total [3];
    int     m_cnt   [3];
    bit     m_hold  [3];

    always #5 clk = ~clk;

    dot_product_acc #(.ACC_W(16), .LEN(4)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_prod(in_prod[0]), .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_count(out_count[0]), .out_ovf(out_ovf[0]));

    dot_product_acc #(.ACC_W(16), .LEN(8)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_prod(in_prod[1]), .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_count(out_count[1]), .out_ovf(out_ovf[1]));

    dot_product_acc #(.ACC_W(10), .LEN(5)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_prod(in_prod[2]), .in_last(in_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_count(out_count[2]), .out_ovf(out_ovf[2]));

    function automatic int acc_w(input int s);
        return (s == 2) ? 10 : 16;
    endfunction

    function automatic int len(input int s);
        return (s == 0) ? 4 : (s == 1) ? 8 : 5;
    endfunction

    function automatic logic [31:0] sum_of(input int s);
        case (s)
            0:       return 32'(sum0);
            1:       return 32'(sum1);
            default: return 32'(sum2);
        endcase
    endfunction

    // Expected result from the true (unbounded) total of all terms.
    function automatic logic [31:0] exp_sum(input int s);
        longint maxv = (64'd1 << acc_w(s)) - 1;
`ifdef DOTACC_SAT_EN
        return 32'((m_total[s] > maxv) ? maxv : m_total[s]);
`else
        return 32'(m_total[s] % (maxv + 1));
`endif
    endfunction

    function automatic logic exp_ovf(input int s);
        return m_total[s] > ((64'd1 << acc_w(s)) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int s);
        m_total[s] = 0;
        m_cnt[s]   = 0;
        m_hold[s]  = 1'b0;
    endtask

    // One clock cycle on instance s; other instances idle and keep their state.
    task automatic step(input int s, input bit v, input bit [7:0] p, input bit l, input bit r, input bit c);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = (i == s) && v;
            in_last[i]   = (i == s) && l;
            out_ready[i] = (i == s) && r;
            clr[i]       = (i == s) && c;
            in_prod[i]   = (i == s) ? p : 8'($urandom);
        end
        #1;
        check($sformatf("s%0d in_ready", s), 32'(in_ready[s]), 32'(!m_hold[s] && !c));
        check($sformatf("s%0d out_valid", s), 32'(out_valid[s]), 32'(m_hold[s]));
        if (m_hold[s]) begin
            check($sformatf("s%0d out_sum", s), sum_of(s), exp_sum(s));
            check($sformatf("s%0d out_count", s), 32'(out_count[s]), 32'(m_cnt[s]));
            check($sformatf("s%0d out_ovf", s), 32'(out_ovf[s]), 32'(exp_ovf(s)));
        end
        @(posedge clk);
        if (c) begin
            model_clear(s);
        end else if (m_hold[s]) begin
            if (r) model_clear(s);
        end else if (v) begin
            m_total[s] += longint'(p);
            m_cnt[s]++;
            if (l || m_cnt[s] == len(s)) m_hold[s] = 1'b1;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s s%0d in_ready", tag, i), 32'(in_ready[i]), 32'd0);
            check($sformatf("%s s%0d out_valid", tag, i), 32'(out_valid[i]), 32'd0);
            check($sformatf("%s s%0d out_sum", tag, i), sum_of(i), 32'd0);
            check($sformatf("%s s%0d out_count", tag, i), 32'(out_count[i]), 32'd0);
            check($sformatf("%s s%0d out_ovf", tag, i), 32'(out_ovf[i]), 32'd0);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        in_valid = '0; clr = '0; out_ready = '0; in_last = '0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) model_clear(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("%s s%0d ready after release", tag, i), 32'(in_ready[i]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        clr = '0; in_valid = '0; in_last = '0; out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_prod[i] = '0;
            model_clear(i);
        end
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full-length run on LEN=4
        for (int k = 0; k < 4; k++) step(0, 1, 8'd225, 0, 1, 0);
        check("t1 sum", sum_of(0), 32'd900);
        check("t1 count", 32'(out_count[0]), 32'd4);
        check("t1 ovf", 32'(out_ovf[0]), 32'd0);
        step(0, 0, 8'd0, 0, 1, 0);
        check("t1 ready again", 32'(in_ready[0]), 32'd1);

        // Early end on LEN=8, then accumulator restarts from zero
        step(1, 1, 8'd10, 0, 0, 0);
        step(1, 1, 8'd20, 1, 0, 0);
        check("t2 sum a", sum_of(1), 32'd30);
        check("t2 count a", 32'(out_count[1]), 32'd2);
        step(1, 0, 8'd0, 0, 1, 0);
        step(1, 1, 8'd7, 1, 0, 0);
        check("t2 sum b", sum_of(1), 32'd7);
        check("t2 count b", 32'(out_count[1]), 32'd1);
        step(1, 0, 8'd0, 0, 1, 0);

        // Backpressure while holding
        step(1, 1, 8'd3, 0, 0, 0);
        step(1, 1, 8'd4, 1, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 8'd99, 0, 0, 0);
        check("t3 held sum", sum_of(1), 32'd7);
        check("t3 held count", 32'(out_count[1]), 32'd2);
        step(1, 1, 8'd99, 0, 1, 0);
        check("t3 valid drops", 32'(out_valid[1]), 32'd0);
        step(1, 1, 8'd5, 1, 0, 0);
        check("t3 resume sum", sum_of(1), 32'd5);
        check("t3 resume count", 32'(out_count[1]), 32'd1);
        step(1, 0, 8'd0, 0, 1, 0);

        // Overflow on ACC_W=10, LEN=5
        for (int k = 0; k < 5; k++) step(2, 1, 8'd225, 0, 0, 0);
`ifdef DOTACC_SAT_EN
        check("t4 sum", sum_of(2), 32'd1023);
`else
        check("t4 sum", sum_of(2), 32'd101);
`endif
        check("t4 ovf", 32'(out_ovf[2]), 32'd1);
        check("t4 count", 32'(out_count[2]), 32'd5);
        step(2, 0, 8'd0, 0, 1, 0);

        // Abort mid-accumulation, then a clean full run with in_last on the LEN beat
        for (int k = 0; k < 3; k++) step(0, 1, 8'd50, 0, 0, 0);
        step(0, 1, 8'd50, 0, 0, 1);
        check("t5 cleared count", 32'(out_count[0]), 32'd0);
        check("t5 cleared sum", sum_of(0), 32'd0);
        for (int k = 0; k < 4; k++) step(0, 1, 8'd1, (k == 3), 0, 0);
        check("t5 sum", sum_of(0), 32'd4);
        check("t5 count", 32'(out_count[0]), 32'd4);
        step(0, 0, 8'd0, 0, 1, 0);

        // Async reset mid-accumulation and while holding
        step(0, 1, 8'd77, 0, 0, 0);
        step(0, 1, 8'd88, 0, 0, 0);
        pulse_reset("rst accum");
        step(1, 1, 8'd12, 1, 0, 0);
        pulse_reset("rst hold");

        // Randomised traffic across all three configurations
        for (int k = 0; k < 1500; k++) begin
            automatic int  s = k % 3;
            automatic bit  v = ($urandom_range(0, 3) != 0);
            automatic bit [7:0] p = 8'($urandom);
            automatic bit  l = ($urandom_range(0, 5) == 0);
            automatic bit  r = ($urandom_range(0, 2) != 0);
            automatic bit  c = ($urandom_range(0, 39) == 0);
            step(s, v, p, l, r, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
